// File: rtl/alu_cmd_pkg.sv
// Shared definitions for the ALU command sequencer: FSM encoding, command bytes
// and the ALU function codes used by the ALU, the sequencer and their benches.
package alu_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GET_A   = 3'd1,
        ST_GET_B   = 3'd2,
        ST_GET_FUN = 3'd3,
        ST_EXEC    = 3'd4,
        ST_WAIT    = 3'd5,
        ST_SEND_LO = 3'd6,
        ST_SEND_HI = 3'd7
    } state_t;

    localparam logic [7:0] CMD_FULL_DEF  = 8'hCC;
    localparam logic [7:0] CMD_REUSE_DEF = 8'hDD;

    localparam logic [3:0] FUN_ADD    = 4'd0;
    localparam logic [3:0] FUN_SUB    = 4'd1;
    localparam logic [3:0] FUN_MUL    = 4'd2;
    localparam logic [3:0] FUN_DIV    = 4'd3;
    localparam logic [3:0] FUN_AND    = 4'd4;
    localparam logic [3:0] FUN_OR     = 4'd5;
    localparam logic [3:0] FUN_NAND   = 4'd6;
    localparam logic [3:0] FUN_NOR    = 4'd7;
    localparam logic [3:0] FUN_XOR    = 4'd8;
    localparam logic [3:0] FUN_XNOR   = 4'd9;
    localparam logic [3:0] FUN_CMP_EQ = 4'd10;
    localparam logic [3:0] FUN_CMP_GT = 4'd11;
    localparam logic [3:0] FUN_CMP_LT = 4'd12;
    localparam logic [3:0] FUN_SHR    = 4'd13;
    localparam logic [3:0] FUN_SHL    = 4'd14;
    localparam logic [3:0] FUN_NOP    = 4'd15;

endpackage

// File: rtl/alu_cmd_ctrl.sv
// Byte-serial command sequencer: parses a command frame, fires the ALU once,
// waits (with a watchdog) for its result and returns it low byte first.
module alu_cmd_ctrl
    import alu_cmd_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    OUT_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] CMD_FULL   = DATA_WIDTH'(CMD_FULL_DEF),
    parameter logic [DATA_WIDTH-1:0] CMD_REUSE  = DATA_WIDTH'(CMD_REUSE_DEF),
    parameter int                    TIMEOUT    = 15
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [3:0]            alu_fun,
    output logic                  alu_en,
    input  logic [OUT_WIDTH-1:0]  alu_out,
    input  logic                  alu_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t                state, state_next;
    logic [WD_W-1:0]       wd_cnt;
    logic [OUT_WIDTH-1:0]  result;
    logic                  bad_cmd;
    logic                  wd_expire;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        bad_cmd    = 1'b0;
        wd_expire  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_FULL)       state_next = ST_GET_A;
                    else if (rx_data == CMD_REUSE) state_next = ST_GET_FUN;
                    else                           bad_cmd    = 1'b1;
                end
            end
            ST_GET_A:   if (rx_valid) state_next = ST_GET_B;
            ST_GET_B:   if (rx_valid) state_next = ST_GET_FUN;
            ST_GET_FUN: if (rx_valid) state_next = ST_EXEC;
            ST_EXEC:    state_next = ST_WAIT;
            ST_WAIT: begin
                // A result arriving on the last watchdog cycle still counts.
                if (alu_valid) begin
                    state_next = ST_SEND_LO;
                end else if (wd_cnt == WD_W'(TIMEOUT)) begin
                    wd_expire  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_SEND_LO: if (tx_ready) state_next = ST_SEND_HI;
            ST_SEND_HI: if (tx_ready) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_fun  <= '0;
            alu_en   <= 1'b0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            wd_cnt   <= '0;
            result   <= '0;
        end else begin
            alu_en   <= (state_next == ST_EXEC);
            busy     <= (state_next != ST_IDLE);
            tx_valid <= (state_next == ST_SEND_LO) || (state_next == ST_SEND_HI);
            err      <= bad_cmd || wd_expire;

            if (rx_valid && state == ST_GET_A)   alu_a   <= rx_data;
            if (rx_valid && state == ST_GET_B)   alu_b   <= rx_data;
            if (rx_valid && state == ST_GET_FUN) alu_fun <= rx_data[3:0];

            if (state == ST_EXEC)      wd_cnt <= WD_W'(1);
            else if (state == ST_WAIT) wd_cnt <= wd_cnt + WD_W'(1);

            if (state == ST_WAIT && alu_valid) begin
                result  <= alu_out;
                tx_data <= alu_out[DATA_WIDTH-1:0];
            end else if (state == ST_SEND_LO && tx_ready) begin
                tx_data <= result[OUT_WIDTH-1:DATA_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl with a one-cycle registered ALU model and a
// frame-level reference model tracking the operands the sequencer should hold.
module tb_alu_cmd_ctrl;
    import alu_cmd_pkg::*;

    localparam int T = 15;

    logic        CLK, RST;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_fun;
    logic        alu_en;
    logic [15:0] alu_out;
    logic        alu_valid;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready, busy, err;

    int pass_cnt = 0;
    int total    = 0;
    int en_cnt = 0, err_cnt = 0, hold_viol = 0, busy_viol = 0;
    logic [7:0] tx_q[$];
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       alu_mute  = 1'b0;
    logic [7:0] model_a = 8'h00, model_b = 8'h00;

    alu_cmd_ctrl #(.TIMEOUT(T)) dut (
        .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_en(alu_en),
        .alu_out(alu_out), .alu_valid(alu_valid), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .err(err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] f);
        case (f)
            FUN_ADD:    return 16'(a) + 16'(b);
            FUN_SUB:    return 16'(a) - 16'(b);
            FUN_MUL:    return 16'(a) * 16'(b);
            FUN_DIV:    return (b == 0) ? 16'h0000 : 16'(a / b);
            FUN_AND:    return {8'h00, a & b};
            FUN_OR:     return {8'h00, a | b};
            FUN_NAND:   return {8'h00, ~(a & b)};
            FUN_NOR:    return {8'h00, ~(a | b)};
            FUN_XOR:    return {8'h00, a ^ b};
            FUN_XNOR:   return {8'h00, ~(a ^ b)};
            FUN_CMP_EQ: return (a == b) ? 16'd1 : 16'd0;
            FUN_CMP_GT: return (a > b) ? 16'd1 : 16'd0;
            FUN_CMP_LT: return (a < b) ? 16'd1 : 16'd0;
            FUN_SHR:    return {8'h00, a >> 1};
            FUN_SHL:    return 16'(a) << 1;
            default:    return 16'h0000;
        endcase
    endfunction

    // Registered ALU: result and valid appear the cycle after alu_en.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            alu_valid <= 1'b0;
            alu_out   <= 16'h0000;
        end else begin
            alu_valid <= alu_en && !alu_mute;
            if (alu_en) alu_out <= alu_ref(alu_a, alu_b, alu_fun);
        end
    end

    always @(negedge CLK) begin
        if (RST) begin
            prev_hold <= 1'b0;
        end else begin
            if (alu_en) en_cnt <= en_cnt + 1;
            if (err) err_cnt <= err_cnt + 1;
            if (prev_hold && (!tx_valid || tx_data !== prev_data)) hold_viol <= hold_viol + 1;
            if (tx_valid && !busy) busy_viol <= busy_viol + 1;
            if (tx_valid && tx_ready) tx_q.push_back(tx_data);
            prev_hold <= tx_valid && !tx_ready;
            prev_data <= tx_data;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            if (rnd) begin
                tx_ready = 1'($urandom_range(0, 1));
                rx_data  = 8'($urandom);
                rx_valid = ($urandom_range(0, 3) == 0);
            end
        end
        rx_valid = 1'b0;
        tx_ready = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({alu_a, alu_b, alu_fun, alu_en, tx_data, tx_valid, busy, err} !== 33'h0)
            $display("FAIL reset_outputs: got a=%0h b=%0h fun=%0h en=%0b tx=%0h txv=%0b busy=%0b err=%0b required all 0",
                     alu_a, alu_b, alu_fun, alu_en, tx_data, tx_valid, busy, err);
        else pass_cnt++;
        @(posedge CLK);
        #1 RST = 1'b0;
        step();
        total++;
        if (busy !== 1'b0 || err !== 1'b0)
            $display("FAIL reset_release_idle: got busy=%0b err=%0b required 0/0", busy, err);
        else pass_cnt++;
    endtask

    task automatic test_full();
        int e0 = en_cnt;
        int q0 = tx_q.size();
        int bv0 = busy_viol;
        tx_ready = 1'b1;
        send_byte(8'hCC);
        total++;
        if (busy !== 1'b1) $display("FAIL full_busy_after_cmd: got %0b required 1", busy);
        else pass_cnt++;
        send_byte(8'h0F);
        send_byte(8'h03);
        send_byte({4'h0, FUN_ADD});
        total++;
        if (alu_en !== 1'b1 || alu_a !== 8'h0F || alu_b !== 8'h03 || alu_fun !== FUN_ADD)
            $display("FAIL full_alu_en: got en=%0b a=%0h b=%0h fun=%0h required 1/0f/03/0",
                     alu_en, alu_a, alu_b, alu_fun);
        else pass_cnt++;
        step();
        total++;
        if (alu_en !== 1'b0) $display("FAIL full_en_one_cycle: got %0b required 0", alu_en);
        else pass_cnt++;
        step();
        total++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h12)
            $display("FAIL full_tx_lo: got v=%0b d=%0h required 1/12", tx_valid, tx_data);
        else pass_cnt++;
        step();
        total++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h00 || busy !== 1'b1)
            $display("FAIL full_tx_hi: got v=%0b d=%0h busy=%0b required 1/00/1", tx_valid, tx_data, busy);
        else pass_cnt++;
        step();
        total++;
        if (busy !== 1'b0 || tx_valid !== 1'b0)
            $display("FAIL full_idle: got busy=%0b txv=%0b required 0/0", busy, tx_valid);
        else pass_cnt++;
        total++;
        if (en_cnt - e0 != 1) $display("FAIL full_en_count: got %0d required 1", en_cnt - e0);
        else pass_cnt++;
        total++;
        if (tx_q.size() != q0 + 2 || tx_q[q0] !== 8'h12 || tx_q[q0+1] !== 8'h00)
            $display("FAIL full_tx_bytes: got %0d bytes required 12,00", tx_q.size() - q0);
        else pass_cnt++;
        total++;
        if (busy_viol != bv0) $display("FAIL full_busy_during_tx: got %0d drops required 0", busy_viol - bv0);
        else pass_cnt++;
        model_a = 8'h0F;
        model_b = 8'h03;
    endtask

    task automatic test_reuse();
        int q0 = tx_q.size();
        bit ok;
        send_byte(8'hDD);
        send_byte({4'h0, FUN_MUL});
        wait_done(50, 1'b0, ok);
        total++;
        if (!ok) $display("FAIL reuse_done: got timeout required completion");
        else pass_cnt++;
        total++;
        if (tx_q.size() != q0 + 2 || tx_q[q0] !== 8'h2D || tx_q[q0+1] !== 8'h00)
            $display("FAIL reuse_tx_bytes: got %0d bytes required 2d,00", tx_q.size() - q0);
        else pass_cnt++;
        total++;
        if (alu_a !== model_a || alu_b !== model_b)
            $display("FAIL reuse_operands: got %0h/%0h required %0h/%0h", alu_a, alu_b, model_a, model_b);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int q0 = tx_q.size();
        bit ok, seen, stable;
        tx_ready = 1'b0;
        send_byte(8'hDD);
        send_byte({4'h0, FUN_MUL});
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            seen = tx_valid;
        end
        total++;
        if (!seen) $display("FAIL bp_tx_valid: got no tx_valid within 20 cycles required 1");
        else pass_cnt++;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (tx_valid !== 1'b1 || tx_data !== 8'h2D) stable = 1'b0;
        end
        total++;
        if (!stable) $display("FAIL bp_hold: got v=%0b d=%0h required 1/2d held", tx_valid, tx_data);
        else pass_cnt++;
        total++;
        if (tx_q.size() != q0) $display("FAIL bp_no_handshake: got %0d bytes required 0", tx_q.size() - q0);
        else pass_cnt++;
        tx_ready = 1'b1;
        wait_done(20, 1'b0, ok);
        total++;
        if (!ok || tx_q.size() != q0 + 2 || tx_q[q0] !== 8'h2D || tx_q[q0+1] !== 8'h00)
            $display("FAIL bp_tx_bytes: got ok=%0b %0d bytes required 2d,00", ok, tx_q.size() - q0);
        else pass_cnt++;
    endtask

    task automatic test_bad_cmd();
        int e0 = en_cnt;
        int r0 = err_cnt;
        int q0;
        bit ok;
        send_byte(8'h55);
        total++;
        if (err !== 1'b1 || busy !== 1'b0)
            $display("FAIL bad_err_pulse: got err=%0b busy=%0b required 1/0", err, busy);
        else pass_cnt++;
        step();
        total++;
        if (err !== 1'b0 || en_cnt != e0 || err_cnt - r0 != 1)
            $display("FAIL bad_single: got err=%0b en=%0d errs=%0d required 0/0/1", err, en_cnt - e0, err_cnt - r0);
        else pass_cnt++;
        q0 = tx_q.size();
        send_byte(8'hCC);
        send_byte(8'h04);
        send_byte(8'h02);
        send_byte({4'h0, FUN_SHR});
        wait_done(50, 1'b0, ok);
        total++;
        if (!ok || tx_q.size() != q0 + 2 || tx_q[q0] !== 8'h02 || tx_q[q0+1] !== 8'h00)
            $display("FAIL bad_recovery: got ok=%0b %0d bytes required 02,00", ok, tx_q.size() - q0);
        else pass_cnt++;
        model_a = 8'h04;
        model_b = 8'h02;
    endtask

    task automatic test_watchdog();
        int q0 = tx_q.size();
        bit early;
        alu_mute = 1'b1;
        send_byte(8'hCC);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte({4'h0, FUN_ADD});
        total++;
        if (alu_en !== 1'b1) $display("FAIL wd_alu_en: got %0b required 1", alu_en);
        else pass_cnt++;
        early = 1'b0;
        for (int k = 1; k <= T; k++) begin
            step();
            if (err !== 1'b0 || tx_valid !== 1'b0 || busy !== 1'b1) early = 1'b1;
        end
        total++;
        if (early) $display("FAIL wd_wait_phase: got early err/tx/idle required busy wait of %0d cycles", T);
        else pass_cnt++;
        step();
        total++;
        if (err !== 1'b1 || busy !== 1'b0)
            $display("FAIL wd_expiry: got err=%0b busy=%0b required 1/0", err, busy);
        else pass_cnt++;
        step();
        total++;
        if (err !== 1'b0 || tx_valid !== 1'b0 || tx_q.size() != q0)
            $display("FAIL wd_after: got err=%0b txv=%0b bytes=%0d required 0/0/0", err, tx_valid, tx_q.size() - q0);
        else pass_cnt++;
        alu_mute = 1'b0;
        model_a = 8'h11;
        model_b = 8'h22;
    endtask

    task automatic test_reset_midop();
        int q0;
        bit ok, seen;
        tx_ready = 1'b0;
        send_byte(8'hCC);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte({4'h0, FUN_ADD});
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            seen = tx_valid;
        end
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        #2;
        total++;
        if (!seen || tx_valid !== 1'b1 || tx_data !== 8'h00)
            $display("FAIL rst_reach_send_hi: got v=%0b d=%0h required 1/00", tx_valid, tx_data);
        else pass_cnt++;
        RST = 1'b1;
        #1;
        total++;
        if ({alu_a, alu_b, alu_fun, alu_en, tx_data, tx_valid, busy, err} !== 33'h0)
            $display("FAIL rst_async: got a=%0h b=%0h tx=%0h txv=%0b busy=%0b required all 0",
                     alu_a, alu_b, tx_data, tx_valid, busy);
        else pass_cnt++;
        #2 RST = 1'b0;
        tx_ready = 1'b1;
        step();
        model_a = 8'h00;
        model_b = 8'h00;
        q0 = tx_q.size();
        send_byte(8'hDD);
        send_byte({4'h0, FUN_NOR});
        wait_done(50, 1'b0, ok);
        total++;
        if (!ok || tx_q.size() != q0 + 2 || tx_q[q0] !== 8'hFF || tx_q[q0+1] !== 8'h00)
            $display("FAIL rst_reuse_zero_ops: got ok=%0b %0d bytes required ff,00", ok, tx_q.size() - q0);
        else pass_cnt++;
        q0 = tx_q.size();
        send_byte(8'hCC);
        send_byte(8'h07);
        send_byte(8'h06);
        send_byte({4'h0, FUN_MUL});
        wait_done(50, 1'b0, ok);
        total++;
        if (!ok || tx_q.size() != q0 + 2 || tx_q[q0] !== 8'h2A || tx_q[q0+1] !== 8'h00)
            $display("FAIL rst_fresh_frame: got ok=%0b %0d bytes required 2a,00", ok, tx_q.size() - q0);
        else pass_cnt++;
        model_a = 8'h07;
        model_b = 8'h06;
    endtask

    task automatic test_random();
        int hv0 = hold_viol;
        int bv0 = busy_viol;
        for (int n = 0; n < 25; n++) begin
            bit full, ok;
            logic [7:0] a, b, lo, hi;
            logic [3:0] f;
            logic [15:0] exp;
            int q0 = tx_q.size();
            full = ($urandom_range(0, 9) < 7);
            a = 8'($urandom);
            b = 8'($urandom);
            f = 4'($urandom);
            send_byte(full ? 8'hCC : 8'hDD);
            if (full) begin
                repeat ($urandom_range(0, 2)) step();
                send_byte(a);
                repeat ($urandom_range(0, 2)) step();
                send_byte(b);
                model_a = a;
                model_b = b;
            end
            repeat ($urandom_range(0, 2)) step();
            send_byte({4'($urandom), f});
            exp = alu_ref(model_a, model_b, f);
            wait_done(100, 1'b1, ok);
            lo = (tx_q.size() > q0) ? tx_q[q0] : 8'hxx;
            hi = (tx_q.size() > q0 + 1) ? tx_q[q0+1] : 8'hxx;
            total++;
            if (!ok || tx_q.size() != q0 + 2 || lo !== exp[7:0] || hi !== exp[15:8])
                $display("FAIL rand_frame%0d: got ok=%0b bytes=%0d %0h,%0h required %0h,%0h",
                         n, ok, tx_q.size() - q0, lo, hi, exp[7:0], exp[15:8]);
            else pass_cnt++;
        end
        total++;
        if (hold_viol != hv0) $display("FAIL rand_tx_hold: got %0d violations required 0", hold_viol - hv0);
        else pass_cnt++;
        total++;
        if (busy_viol != bv0) $display("FAIL rand_busy: got %0d violations required 0", busy_viol - bv0);
        else pass_cnt++;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish required finish within 500000 ns");
        $fatal(1, "timeout");
    end

    initial begin
        RST      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        test_reset();
        test_full();
        test_reuse();
        test_backpressure();
        test_bad_cmd();
        test_watchdog();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
